id_ex_stage: RTL and testbench

- Pipeline register between the decode stage (control unit plus register-file read) and the execute stage.
- Latches the decoded control word (wmem, rmem, wreg, wpc, jmpF, ALUins, ExtndSel), the operands and the register addresses.
- Detects load-use hazards and inserts bubbles.
- Honours external stall and flush requests from memory and branch resolution.

---
 rtl/id_ex_stage.sv | 163 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches the decoded control word, operands and register
// addresses, inserts load-use bubbles and honours external stall/flush requests.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_wmem,
   input  logic              id_rmem,
   input  logic              id_wreg,
   input  logic              id_wpc,
   input  logic [1:0]        id_jmpF,
   input  logic [2:0]        id_ALUins,
   input  logic [1:0]        id_ExtndSel,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [DATA_W-1:0] id_a,
   input  logic [DATA_W-1:0] id_b,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              stall_i,
   input  logic              flush_i,
   output logic              ex_wmem,
   output logic              ex_rmem,
   output logic              ex_wreg,
   output logic              ex_wpc,
   output logic [1:0]        ex_jmpF,
   output logic [2:0]        ex_ALUins,
   output logic [1:0]        ex_ExtndSel,
   output logic              ex_valid,
   output logic [REG_AW-1:0] ex_rd,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [DATA_W-1:0] ex_imm,
   output logic              hold_o,
   output logic [15:0]       bubble_cnt
);

   localparam logic [1:0] SEL_HOLD   = 2'd0;
   localparam logic [1:0] SEL_BUBBLE = 2'd1;
   localparam logic [1:0] SEL_LOAD   = 2'd2;

   logic              ex_wmem_r, ex_rmem_r, ex_wreg_r, ex_wpc_r, ex_valid_r;
   logic [1:0]        ex_jmpF_r, ex_ExtndSel_r;
   logic [2:0]        ex_ALUins_r;
   logic [REG_AW-1:0] ex_rd_r;
   logic [DATA_W-1:0] ex_a_r, ex_b_r, ex_imm_r;
   logic [15:0]       bubble_cnt_r;
   logic              luh_s;
   logic              cnt_inc_s;
   logic [1:0]        sel_s;

   // Load-use hazard detection against the load currently in EX
   always_comb begin
      luh_s = ex_valid_r & ex_rmem_r & id_valid &
              ((id_rs1_used & (id_rs1 == ex_rd_r)) | (id_rs2_used & (id_rs2 == ex_rd_r)));
   end

   // Next-state selection: flush beats stall beats hazard; an invalid ID slot becomes a bubble
   always_comb begin
      sel_s     = SEL_HOLD;
      cnt_inc_s = 1'b0;
      if (flush_i) begin
         sel_s = SEL_BUBBLE;
      end else if (stall_i) begin
         sel_s = SEL_HOLD;
      end else if (luh_s) begin
         sel_s     = SEL_BUBBLE;
         cnt_inc_s = 1'b1;
      end else if (!id_valid) begin
         sel_s = SEL_BUBBLE;
      end else begin
         sel_s = SEL_LOAD;
      end
   end

   // Hold request to PC and IF/ID; forced low while reset is asserted
   assign hold_o = rst_n & ((luh_s & ~flush_i) | stall_i);

   // Control word, valid flag and destination address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_wmem_r     <= 1'b0;
         ex_rmem_r     <= 1'b0;
         ex_wreg_r     <= 1'b0;
         ex_wpc_r      <= 1'b0;
         ex_jmpF_r     <= 2'd0;
         ex_ALUins_r   <= 3'd0;
         ex_ExtndSel_r <= 2'd0;
         ex_valid_r    <= 1'b0;
         ex_rd_r       <= {REG_AW{1'b0}};
      end else begin
         case (sel_s)
            SEL_LOAD: begin
               ex_wmem_r     <= id_wmem;
               ex_rmem_r     <= id_rmem;
               ex_wreg_r     <= id_wreg;
               ex_wpc_r      <= id_wpc;
               ex_jmpF_r     <= id_jmpF;
               ex_ALUins_r   <= id_ALUins;
               ex_ExtndSel_r <= id_ExtndSel;
               ex_valid_r    <= 1'b1;
               ex_rd_r       <= id_rd;
            end
            SEL_BUBBLE: begin
               ex_wmem_r     <= 1'b0;
               ex_rmem_r     <= 1'b0;
               ex_wreg_r     <= 1'b0;
               ex_wpc_r      <= 1'b0;
               ex_jmpF_r     <= 2'd0;
               ex_ALUins_r   <= 3'd0;
               ex_ExtndSel_r <= 2'd0;
               ex_valid_r    <= 1'b0;
               ex_rd_r       <= {REG_AW{1'b0}};
            end
            default: begin
               ex_valid_r <= ex_valid_r;
            end
         endcase
      end
   end

   // Operand registers; bubbles leave them untouched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_a_r   <= {DATA_W{1'b0}};
         ex_b_r   <= {DATA_W{1'b0}};
         ex_imm_r <= {DATA_W{1'b0}};
      end else if (sel_s == SEL_LOAD) begin
         ex_a_r   <= id_a;
         ex_b_r   <= id_b;
         ex_imm_r <= id_imm;
      end
   end

   // Saturating count of load-use bubbles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt_r <= 16'd0;
      end else if (cnt_inc_s && (bubble_cnt_r != 16'hFFFF)) begin
         bubble_cnt_r <= bubble_cnt_r + 16'd1;
      end
   end

   assign ex_wmem     = ex_wmem_r;
   assign ex_rmem     = ex_rmem_r;
   assign ex_wreg     = ex_wreg_r;
   assign ex_wpc      = ex_wpc_r;
   assign ex_jmpF     = ex_jmpF_r;
   assign ex_ALUins   = ex_ALUins_r;
   assign ex_ExtndSel = ex_ExtndSel_r;
   assign ex_valid    = ex_valid_r;
   assign ex_rd       = ex_rd_r;
   assign ex_a        = ex_a_r;
   assign ex_b        = ex_b_r;
   assign ex_imm      = ex_imm_r;
   assign bubble_cnt  = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver pushes hand-computed EX state per edge,
// a monitor pops and compares it after each rising edge.
module tb_id_ex_stage;

   typedef struct {
      logic        v;
      logic [10:0] ctl;
      logic [3:0]  rd;
      logic [31:0] a, b, imm;
      logic [15:0] cnt;
      bit          chk_data;
   } exp_t;

   logic        clk, rst_n;
   logic        id_wmem, id_rmem, id_wreg, id_wpc, id_valid, id_rs1_used, id_rs2_used;
   logic [1:0]  id_jmpF, id_ExtndSel;
   logic [2:0]  id_ALUins;
   logic [3:0]  id_rd, id_rs1, id_rs2;
   logic [31:0] id_a, id_b, id_imm;
   logic        stall_i, flush_i;
   logic        ex_wmem, ex_rmem, ex_wreg, ex_wpc, ex_valid, hold_o;
   logic [1:0]  ex_jmpF, ex_ExtndSel;
   logic [2:0]  ex_ALUins;
   logic [3:0]  ex_rd;
   logic [31:0] ex_a, ex_b, ex_imm;
   logic [15:0] bubble_cnt;

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t sb_q[$];

   id_ex_stage #(.DATA_W(32), .REG_AW(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_wmem(id_wmem), .id_rmem(id_rmem), .id_wreg(id_wreg), .id_wpc(id_wpc),
      .id_jmpF(id_jmpF), .id_ALUins(id_ALUins), .id_ExtndSel(id_ExtndSel),
      .id_valid(id_valid), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_a(id_a), .id_b(id_b), .id_imm(id_imm),
      .stall_i(stall_i), .flush_i(flush_i),
      .ex_wmem(ex_wmem), .ex_rmem(ex_rmem), .ex_wreg(ex_wreg), .ex_wpc(ex_wpc),
      .ex_jmpF(ex_jmpF), .ex_ALUins(ex_ALUins), .ex_ExtndSel(ex_ExtndSel),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
      .hold_o(hold_o), .bubble_cnt(bubble_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [10:0] mkctl(input logic wm, input logic rm, input logic wr,
                                         input logic wp, input logic [1:0] j,
                                         input logic [2:0] alu, input logic [1:0] ext);
      return {wm, rm, wr, wp, j, alu, ext};
   endfunction

   localparam logic [10:0] C_ALU = {1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b101, 2'b00};
   localparam logic [10:0] C_LD  = {1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 2'b01};
   localparam logic [10:0] C_OP  = {1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b010, 2'b00};
   localparam logic [10:0] C_ST  = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b01};
   localparam logic [10:0] C_BR  = {1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b001, 2'b10};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t ld(input logic [10:0] c, input logic [3:0] rd, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] imm, input logic [15:0] cnt);
      exp_t e;
      e.v = 1'b1; e.ctl = c; e.rd = rd; e.a = a; e.b = b; e.imm = imm; e.cnt = cnt; e.chk_data = 1'b1;
      return e;
   endfunction

   function automatic exp_t bub(input logic [15:0] cnt);
      exp_t e;
      e.v = 1'b0; e.ctl = 11'd0; e.rd = 4'd0; e.a = 32'd0; e.b = 32'd0; e.imm = 32'd0;
      e.cnt = cnt; e.chk_data = 1'b0;
      return e;
   endfunction

   // Waits for the falling edge and presents one decode slot
   task automatic set_id(input logic v, input logic [10:0] c, input logic [3:0] rd,
                         input logic [3:0] rs1, input logic u1, input logic [3:0] rs2,
                         input logic u2, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm);
      @(negedge clk);
      {id_wmem, id_rmem, id_wreg, id_wpc, id_jmpF, id_ALUins, id_ExtndSel} = c;
      id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
      id_a = a; id_b = b; id_imm = imm;
   endtask

   // Applies stall/flush, checks hold_o, queues the expected EX state and lets the edge pass
   task automatic step(input logic fl, input logic st, input logic exp_hold, input exp_t e);
      flush_i = fl;
      stall_i = st;
      #1;
      chk("hold_o", {31'd0, hold_o}, {31'd0, exp_hold});
      sb_q.push_back(e);
      @(posedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " ex_valid"}, {31'd0, ex_valid}, 32'd0);
      chk({tag, " ctl"}, {21'd0, mkctl(ex_wmem, ex_rmem, ex_wreg, ex_wpc, ex_jmpF, ex_ALUins, ex_ExtndSel)}, 32'd0);
      chk({tag, " ex_rd"}, {28'd0, ex_rd}, 32'd0);
      chk({tag, " ex_a"}, ex_a, 32'd0);
      chk({tag, " ex_b"}, ex_b, 32'd0);
      chk({tag, " ex_imm"}, ex_imm, 32'd0);
      chk({tag, " bubble_cnt"}, {16'd0, bubble_cnt}, 32'd0);
      chk({tag, " hold_o"}, {31'd0, hold_o}, 32'd0);
   endtask

   // Monitor: compares the DUT's EX state against the scoreboard after each rising edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.v});
            chk("ex_ctl", {21'd0, mkctl(ex_wmem, ex_rmem, ex_wreg, ex_wpc, ex_jmpF, ex_ALUins, ex_ExtndSel)},
                {21'd0, e.ctl});
            chk("ex_rd", {28'd0, ex_rd}, {28'd0, e.rd});
            chk("bubble_cnt", {16'd0, bubble_cnt}, {16'd0, e.cnt});
            if (e.chk_data) begin
               chk("ex_a", ex_a, e.a);
               chk("ex_b", ex_b, e.b);
               chk("ex_imm", ex_imm, e.imm);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; stall_i = 1'b1; flush_i = 1'b0;
      {id_wmem, id_rmem, id_wreg, id_wpc, id_jmpF, id_ALUins, id_ExtndSel} = 11'd0;
      id_valid = 1'b0; id_rd = 4'd0; id_rs1 = 4'd0; id_rs2 = 4'd0;
      id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_a = 32'd0; id_b = 32'd0; id_imm = 32'd0;
      #2;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1; stall_i = 1'b0;

      // Normal advance, then a load followed by a dependent consumer
      set_id(1'b1, C_ALU, 4'd1, 4'd0, 1'b0, 4'd0, 1'b0, 32'h12, 32'h34, 32'hFFFF_FFF0);
      step(1'b0, 1'b0, 1'b0, ld(C_ALU, 4'd1, 32'h12, 32'h34, 32'hFFFF_FFF0, 16'd0));
      set_id(1'b1, C_LD, 4'd3, 4'd2, 1'b1, 4'd0, 1'b0, 32'h100, 32'h0, 32'h4);
      step(1'b0, 1'b0, 1'b0, ld(C_LD, 4'd3, 32'h100, 32'h0, 32'h4, 16'd0));
      set_id(1'b1, C_OP, 4'd4, 4'd3, 1'b1, 4'd5, 1'b1, 32'hAA, 32'hBB, 32'h0);
      step(1'b0, 1'b0, 1'b1, bub(16'd1));
      step(1'b0, 1'b0, 1'b0, ld(C_OP, 4'd4, 32'hAA, 32'hBB, 32'h0, 16'd1));
      // rs1 matches but is unused: no bubble
      set_id(1'b1, C_LD, 4'd3, 4'd1, 1'b1, 4'd0, 1'b0, 32'h200, 32'h0, 32'h8);
      step(1'b0, 1'b0, 1'b0, ld(C_LD, 4'd3, 32'h200, 32'h0, 32'h8, 16'd1));
      set_id(1'b1, C_OP, 4'd5, 4'd3, 1'b0, 4'd7, 1'b1, 32'hCC, 32'hDD, 32'h0);
      step(1'b0, 1'b0, 1'b0, ld(C_OP, 4'd5, 32'hCC, 32'hDD, 32'h0, 16'd1));
      // Hazard through rs2
      set_id(1'b1, C_LD, 4'd6, 4'd0, 1'b0, 4'd0, 1'b0, 32'h300, 32'h0, 32'hC);
      step(1'b0, 1'b0, 1'b0, ld(C_LD, 4'd6, 32'h300, 32'h0, 32'hC, 16'd1));
      set_id(1'b1, C_BR, 4'd0, 4'd0, 1'b0, 4'd6, 1'b1, 32'h1, 32'h2, 32'h10);
      step(1'b0, 1'b0, 1'b1, bub(16'd2));
      step(1'b0, 1'b0, 1'b0, ld(C_BR, 4'd0, 32'h1, 32'h2, 32'h10, 16'd2));
      // Back-to-back loads to the same register
      set_id(1'b1, C_LD, 4'd2, 4'd0, 1'b1, 4'd0, 1'b0, 32'h400, 32'h0, 32'h0);
      step(1'b0, 1'b0, 1'b0, ld(C_LD, 4'd2, 32'h400, 32'h0, 32'h0, 16'd2));
      set_id(1'b1, C_LD, 4'd2, 4'd2, 1'b1, 4'd0, 1'b0, 32'h500, 32'h0, 32'h4);
      step(1'b0, 1'b0, 1'b1, bub(16'd3));
      step(1'b0, 1'b0, 1'b0, ld(C_LD, 4'd2, 32'h500, 32'h0, 32'h4, 16'd3));
      set_id(1'b1, C_OP, 4'd7, 4'd2, 1'b1, 4'd0, 1'b0, 32'hEE, 32'hFF, 32'h0);
      step(1'b0, 1'b0, 1'b1, bub(16'd4));
      step(1'b0, 1'b0, 1'b0, ld(C_OP, 4'd7, 32'hEE, 32'hFF, 32'h0, 16'd4));
      // Flush together with stall loads a bubble
      set_id(1'b1, C_ALU, 4'd1, 4'd0, 1'b0, 4'd0, 1'b0, 32'h55, 32'h66, 32'h77);
      step(1'b1, 1'b1, 1'b1, bub(16'd4));
      set_id(1'b1, C_LD, 4'd9, 4'd0, 1'b0, 4'd0, 1'b0, 32'h900, 32'h0, 32'h20);
      step(1'b0, 1'b0, 1'b0, ld(C_LD, 4'd9, 32'h900, 32'h0, 32'h20, 16'd4));
      // Stall for three cycles while a hazard is pending: everything frozen
      for (int i = 0; i < 3; i++) begin
         set_id(1'b1, C_OP, 4'd8, 4'd9, 1'b1, 4'd0, 1'b0, 32'h1000 + i, 32'h1, 32'h2);
         step(1'b0, 1'b1, 1'b1, ld(C_LD, 4'd9, 32'h900, 32'h0, 32'h20, 16'd4));
      end
      // Flush overrides the hazard: no hold, no count
      set_id(1'b1, C_OP, 4'd8, 4'd9, 1'b1, 4'd0, 1'b0, 32'h1, 32'h1, 32'h2);
      step(1'b1, 1'b0, 1'b0, bub(16'd4));
      // Invalid slot carrying a store never reaches EX
      set_id(1'b0, C_ST, 4'hA, 4'd9, 1'b1, 4'd0, 1'b0, 32'h3, 32'h4, 32'h5);
      step(1'b0, 1'b0, 1'b0, bub(16'd4));
      // Register 0 is not special
      set_id(1'b1, C_LD, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 32'hAB, 32'h0, 32'h0);
      step(1'b0, 1'b0, 1'b0, ld(C_LD, 4'd0, 32'hAB, 32'h0, 32'h0, 16'd4));
      set_id(1'b1, C_OP, 4'd1, 4'd0, 1'b1, 4'd0, 1'b0, 32'h1, 32'h1, 32'h0);
      step(1'b0, 1'b0, 1'b1, bub(16'd5));
      step(1'b0, 1'b0, 1'b0, ld(C_OP, 4'd1, 32'h1, 32'h1, 32'h0, 16'd5));

      // Asynchronous reset pulse between edges, then a normal load on the next edge
      set_id(1'b1, C_BR, 4'd5, 4'd1, 1'b1, 4'd0, 1'b0, 32'h77, 32'h88, 32'h99);
      flush_i = 1'b0; stall_i = 1'b0;
      #1 rst_n = 1'b0;
      #1 chk_zero("async_reset");
      #1 rst_n = 1'b1;
      step(1'b0, 1'b0, 1'b0, ld(C_BR, 4'd5, 32'h77, 32'h88, 32'h99, 16'd0));

      // Counter saturation: preset near the top while stalled, then drive self-dependent loads
      @(negedge clk);
      stall_i = 1'b1;
      force dut.bubble_cnt_r = 16'hFFFD;
      @(posedge clk);
      #1;
      release dut.bubble_cnt_r;
      set_id(1'b1, C_LD, 4'd3, 4'd3, 1'b1, 4'd0, 1'b0, 32'h1, 32'h0, 32'h0);
      step(1'b0, 1'b0, 1'b0, ld(C_LD, 4'd3, 32'h1, 32'h0, 32'h0, 16'hFFFD));
      step(1'b0, 1'b0, 1'b1, bub(16'hFFFE));
      step(1'b0, 1'b0, 1'b0, ld(C_LD, 4'd3, 32'h1, 32'h0, 32'h0, 16'hFFFE));
      step(1'b0, 1'b0, 1'b1, bub(16'hFFFF));
      step(1'b0, 1'b0, 1'b0, ld(C_LD, 4'd3, 32'h1, 32'h0, 32'h0, 16'hFFFF));
      step(1'b0, 1'b0, 1'b1, bub(16'hFFFF));

      @(negedge clk);
      chk("scoreboard_drained", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
